// File: rtl/pos_ctrl.sv
// pos_ctrl: single-axis position controller driving an external magnitude
// comparator (cmp_a = latched target, cmp_b = current position).
// A move alternates EVAL (one cycle) with a MOVE_UP/MOVE_DOWN phase lasting
// STEP_DIV cycles, each phase ending in a one-unit position step. On arrival
// the block dwells DWELL_CYC cycles, pulses done, and returns to IDLE.
// Optional feature: define POS_CTRL_WDOG_EN to add a step-count watchdog that
// forces FAULT once 127 steps have completed without arrival.
module pos_ctrl #(
  parameter int unsigned STEP_DIV  = 4,
  parameter int unsigned DWELL_CYC = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] target,
  input  logic       clr,
  output logic [6:0] cmp_a,
  output logic [6:0] cmp_b,
  input  logic       aeqb,
  input  logic       agtb,
  input  logic       altb,
  output logic [6:0] pos,
  output logic       up,
  output logic       down,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DWELL,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(STEP_DIV - 1);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYC - 1);

  state_t     state_reg, state_next;
  logic [6:0] pos_reg;
  logic [6:0] cmp_a_reg;
  logic [7:0] presc_reg;
  logic [7:0] dwell_reg;

  logic       in_move;
  logic       presc_last;
  logic       dwell_last;
  logic       accept;
  logic [2:0] flags;
  logic       wdog_trip;

  assign in_move    = (state_reg == S_MOVE_UP) || (state_reg == S_MOVE_DOWN);
  assign presc_last = (presc_reg == PRESC_LAST);
  assign dwell_last = (dwell_reg == DWELL_LAST);
  assign accept     = (state_reg == S_IDLE) && start;
  assign flags      = {aeqb, agtb, altb};

`ifdef POS_CTRL_WDOG_EN
  logic [6:0] steps_reg;

  // Count completed steps of the current move, saturating at 127.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      steps_reg <= 7'd0;
    end else if (accept) begin
      steps_reg <= 7'd0;
    end else if (in_move && presc_last && (steps_reg != 7'h7F)) begin
      steps_reg <= steps_reg + 7'd1;
    end
  end

  assign wdog_trip = (steps_reg == 7'h7F);
`else
  assign wdog_trip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; EVAL treats any flag pattern other than exactly one-hot as a fault.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_EVAL;
      end
      S_EVAL: begin
        if (wdog_trip && (flags != 3'b100)) begin
          state_next = S_FAULT;
        end else begin
          case (flags)
            3'b100:  state_next = S_DWELL;
            3'b010:  state_next = (pos_reg == 7'h7F) ? S_FAULT : S_MOVE_UP;
            3'b001:  state_next = (pos_reg == 7'h00) ? S_FAULT : S_MOVE_DOWN;
            default: state_next = S_FAULT;
          endcase
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (presc_last) state_next = S_EVAL;
      end
      S_DWELL: begin
        if (dwell_last) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_FAULT: begin
        if (clr) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: target latch, step prescaler, position register and dwell counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmp_a_reg <= 7'd0;
      pos_reg   <= 7'd0;
      presc_reg <= 8'd0;
      dwell_reg <= 8'd0;
    end else begin
      if (accept) cmp_a_reg <= target;

      if (in_move) presc_reg <= presc_last ? 8'd0 : presc_reg + 8'd1;
      else         presc_reg <= 8'd0;

      if ((state_reg == S_MOVE_UP) && presc_last)   pos_reg <= pos_reg + 7'd1;
      if ((state_reg == S_MOVE_DOWN) && presc_last) pos_reg <= pos_reg - 7'd1;

      if (state_reg == S_DWELL) dwell_reg <= dwell_last ? 8'd0 : dwell_reg + 8'd1;
      else                      dwell_reg <= 8'd0;
    end
  end

  assign cmp_a = cmp_a_reg;
  assign cmp_b = pos_reg;
  assign pos   = pos_reg;
  assign up    = (state_reg == S_MOVE_UP);
  assign down  = (state_reg == S_MOVE_DOWN);
  assign busy  = (state_reg != S_IDLE) && (state_reg != S_FAULT);
  assign done  = (state_reg == S_DONE);
  assign fault = (state_reg == S_FAULT);

endmodule

// File: tb/tb_pos_ctrl.sv
// Testbench for pos_ctrl (STEP_DIV=4, DWELL_CYC=8) with a behavioural
// magnitude comparator that can be overridden to inject illegal flag patterns.
// Time index k counts clock edges after the edge that accepted start (k=0 is
// the EVAL cycle right after acceptance).
module tb_pos_ctrl;
  localparam int S = 4;
  localparam int D = 8;
  localparam int T = S + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       clr   = 1'b0;
  logic [6:0] target = 7'd0;
  logic [6:0] cmp_a, cmp_b, pos;
  logic       aeqb, agtb, altb, up, down, busy, done, fault;
  logic       force_en  = 1'b0;
  logic [2:0] force_val = 3'b000;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_pos = 0;

  pos_ctrl #(.STEP_DIV(S), .DWELL_CYC(D)) dut (
    .clock(clock), .reset(reset), .start(start), .target(target), .clr(clr),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .aeqb(aeqb), .agtb(agtb), .altb(altb),
    .pos(pos), .up(up), .down(down), .busy(busy), .done(done), .fault(fault)
  );

  assign aeqb = force_en ? force_val[2] : (cmp_a == cmp_b);
  assign agtb = force_en ? force_val[1] : (cmp_a >  cmp_b);
  assign altb = force_en ? force_val[0] : (cmp_a <  cmp_b);

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input int t);
    target = 7'(t);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Expected outputs k edges after accepting a move from p to t.
  function automatic void model(input int p, input int t, input int k,
                                output int e_pos, output int e_up, output int e_down,
                                output int e_busy, output int e_done);
    int d, dir;
    d   = (t > p) ? t - p : p - t;
    dir = (t > p) ? 1 : -1;
    e_pos = t; e_up = 0; e_down = 0; e_busy = 1; e_done = 0;
    if (k < d * T) begin
      e_pos  = p + dir * (k / T);
      e_up   = ((k % T) != 0 && dir > 0) ? 1 : 0;
      e_down = ((k % T) != 0 && dir < 0) ? 1 : 0;
    end else if (k == d * T + D + 1) begin
      e_done = 1;
    end else if (k > d * T + D + 1) begin
      e_busy = 0;
    end
  endfunction

  typedef struct {
    int tgt;
    int chg;
    int exp_dir;
    int exp_done_k;
    int exp_pos;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int ndone, done_k, p, t, d, kmax, lo, hi;
    int e_pos, e_up, e_down, e_busy, e_done;
    bit found;

    // target, retarget+start-while-busy, dir (1 up, 2 down), done edge, final pos
    tbl[0] = '{5,   0, 1, 5 * T + D + 1,   5};
    tbl[1] = '{2,   1, 2, 3 * T + D + 1,   2};
    tbl[2] = '{2,   0, 0, D + 1,           2};
    tbl[3] = '{127, 0, 1, 125 * T + D + 1, 127};

    #1;
    chk("rst_pos", pos, 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_status", {up, down, busy, done, fault}, 0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      accept(tbl[i].tgt);
      ndone = 0;
      done_k = -1;
      for (int k = 0; k < 1000; k++) begin
        if (k == 1) begin
          chk("tbl_up", up, (tbl[i].exp_dir == 1) ? 1 : 0);
          chk("tbl_down", down, (tbl[i].exp_dir == 2) ? 1 : 0);
        end
        if (done) begin
          ndone++;
          if (done_k < 0) done_k = k;
        end
        if (done_k >= 0 && !busy && !done) break;
        if (tbl[i].chg != 0) begin
          if (k == 2) target = 7'd9;
          if (k == 3) start = 1'b1;
          if (k == 4) start = 1'b0;
        end
        step();
      end
      chk("tbl_done_k", done_k, tbl[i].exp_done_k);
      chk("tbl_done_cnt", ndone, 1);
      chk("tbl_pos", pos, tbl[i].exp_pos);
      chk("tbl_cmp_a", cmp_a, tbl[i].tgt);
      cur_pos = tbl[i].exp_pos;
    end

    // agtb at pos=127 must fault without moving; start ignored in FAULT; clr beats start.
    force_en = 1'b1;
    force_val = 3'b010;
    accept(50);
    step();
    chk("bnd_hi_fault", fault, 1);
    chk("bnd_hi_busy", busy, 0);
    chk("bnd_hi_pos", pos, 127);
    target = 7'd9;
    start = 1'b1;
    step();
    chk("flt_start_ign", fault, 1);
    chk("flt_cmp_a", cmp_a, 50);
    clr = 1'b1;
    step();
    chk("clr_exit_fault", fault, 0);
    chk("clr_exit_busy", busy, 0);
    clr = 1'b0;
    start = 1'b0;
    step();
    chk("clr_wins_busy", busy, 0);
    chk("clr_wins_cmp_a", cmp_a, 50);

    // Two flags high in EVAL.
    force_val = 3'b011;
    accept(3);
    step();
    chk("multi_flag_fault", fault, 1);
    chk("multi_flag_busy", busy, 0);
    chk("multi_flag_pos", pos, 127);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("multi_clr", fault, 0);
    force_en = 1'b0;

    // Randomized moves against the reference model, with retargeting and start noise.
    for (int m = 0; m < 12; m++) begin
      p = cur_pos;
      lo = (p > 20) ? p - 20 : 0;
      hi = (p < 107) ? p + 20 : 127;
      t = $urandom_range(hi, lo);
      d = (t > p) ? t - p : p - t;
      kmax = d * T + D + 2;
      accept(t);
      for (int k = 0; k <= kmax; k++) begin
        model(p, t, k, e_pos, e_up, e_down, e_busy, e_done);
        chk("rnd_pos", pos, e_pos);
        chk("rnd_up", up, e_up);
        chk("rnd_down", down, e_down);
        chk("rnd_busy", busy, e_busy);
        chk("rnd_done", done, e_done);
        chk("rnd_fault", fault, 0);
        chk("rnd_cmp_a", cmp_a, t);
        if (k < kmax) begin
          start = ($urandom_range(3, 0) == 0);
          if ($urandom_range(3, 0) == 0) target = 7'($urandom_range(127, 0));
          step();
        end else begin
          start = 1'b0;
        end
      end
      cur_pos = t;
    end

    // Reset mid-move: clear to pos 0, start immediately after release, then reset at pos 3.
    reset = 1'b1;
    step();
    reset = 1'b0;
    accept(10);
    chk("first_start_busy", busy, 1);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (pos == 7'd3 && up) begin
        found = 1;
        break;
      end
      step();
    end
    chk("wait_pos3_up", found, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pos", pos, 0);
    chk("async_rst_cmp_a", cmp_a, 0);
    chk("async_rst_status", {up, down, busy, done, fault}, 0);
    step();
    reset = 1'b0;

    // altb at pos=0 must fault without wrapping.
    force_en = 1'b1;
    force_val = 3'b001;
    accept(20);
    step();
    chk("bnd_lo_fault", fault, 1);
    chk("bnd_lo_pos", pos, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    force_en = 1'b0;
    chk("bnd_lo_clr", fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
